// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with a built-in baud-tick generator.
// Delivers each byte with a one-cycle done strobe and a framing-error flag.
module uart_rx_os #(
    parameter int NB_DATA  = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 163,
    parameter int NB_DIV   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_interfaz_data,
    output logic               o_rx_interfaz_done_data,
    output logic               o_frame_err,
    output logic               o_tick
);

    localparam int                NB_N     = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [NB_DIV-1:0] DIV_LAST = NB_DIV'(BAUD_DIV - 1);
    localparam logic [4:0]        S_MID    = 5'd7;
    localparam logic [4:0]        S_BIT    = 5'd15;
    localparam logic [4:0]        S_STOP   = 5'(SB_TICK - 1);
    localparam logic [NB_N-1:0]   N_LAST   = NB_N'(NB_DATA - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic              rx_meta;
    logic              rx_s;
    logic [NB_DIV-1:0] baud_cnt;
    logic              tick;

    state_t            state_q, state_nx;
    logic [4:0]        s_q, s_nx;
    logic [NB_N-1:0]   n_q, n_nx;
    logic [NB_DATA-1:0] sh_q, sh_nx;
    logic [NB_DATA-1:0] data_q, data_nx;
    logic              err_q, err_nx;
    logic              done_q, done_nx;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            baud_cnt <= '0;
        end else if (baud_cnt == DIV_LAST) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign tick = (baud_cnt == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            s_q     <= s_nx;
            n_q     <= n_nx;
            sh_q    <= sh_nx;
            data_q  <= data_nx;
            err_q   <= err_nx;
            done_q  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        s_nx     = s_q;
        n_nx     = n_q;
        sh_nx    = sh_q;
        data_nx  = data_q;
        err_nx   = err_q;
        done_nx  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nx = ST_START;
                    s_nx     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        // Line back high at mid start bit means it was a glitch.
                        if (!rx_s) begin
                            state_nx = ST_DATA;
                            s_nx     = '0;
                            n_nx     = '0;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        s_nx = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == S_BIT) begin
                        s_nx  = '0;
                        sh_nx = {rx_s, sh_q[NB_DATA-1:1]};
                        if (n_q == N_LAST) begin
                            state_nx = ST_STOP;
                        end else begin
                            n_nx = n_q + 1'b1;
                        end
                    end else begin
                        s_nx = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_q == S_STOP) begin
                        s_nx     = '0;
                        data_nx  = sh_q;
                        err_nx   = ~rx_s;
                        done_nx  = 1'b1;
                        state_nx = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        s_nx = s_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                // Wait out a held-low line instead of decoding it as 0x00 frames.
                if (rx_s) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign o_rx_interfaz_data      = data_q;
    assign o_rx_interfaz_done_data = done_q;
    assign o_frame_err             = err_q;
    assign o_tick                  = tick;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames driven on the serial line, a
// scoreboard queue of {frame_err, byte} popped by an independent monitor.
module tb_uart_rx_os;

    localparam int BIT_CYC = 64;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       done;
    logic       err;
    logic       tick;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done = 0;
    int prev_done = 0;
    int start_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    logic [8:0] exp_q[$];

    uart_rx_os #(
        .NB_DATA (8),
        .SB_TICK (16),
        .BAUD_DIV(4),
        .NB_DIV  (8)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst_n),
        .i_rx                   (rx),
        .o_rx_interfaz_data     (data),
        .o_rx_interfaz_done_data(done),
        .o_frame_err            (err),
        .o_tick                 (tick)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        tests++;
        if (got < lo || got > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Drivers: all assume the caller sits 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic e);
        exp_q.push_back({e, d});
        last_byte = d;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got data %0h err %0b expected no done", data, err);
            end else begin
                check("rx_byte", {23'd0, err, data}, {23'd0, exp_q.pop_front()});
            end
            prev_done = last_done;
            last_done = cyc;
            done_cnt++;
        end
    end

    initial begin
        int n_ticks;
        int last_tick;
        int cnt_before;

        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h0);
        check("reset_done", {31'd0, done}, 32'h0);
        check("reset_err", {31'd0, err}, 32'h0);
        check("reset_tick", {31'd0, tick}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Baud tick: 100 single-cycle pulses every 4 cycles over 400 cycles
        n_ticks   = 0;
        last_tick = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tick) begin
                if (last_tick >= 0) check("tick_gap", cyc - last_tick, 4);
                last_tick = cyc;
                n_ticks++;
            end
        end
        check("tick_count", n_ticks, 100);
        @(posedge clk);
        #1;

        // Clean 0x55 frame and done latency from the start edge
        expect_byte(8'h55, 1'b0);
        send_frame(8'h55, 1'b1);
        idle(2 * BIT_CYC);
        check_range("latency_55", last_done - start_cyc, 606, 614);

        // Start glitch: 12 low cycles must not produce a frame
        cnt_before = done_cnt;
        rx = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        idle(200);
        check("glitch_no_done", done_cnt, cnt_before);
        check("glitch_hold", {24'd0, data}, {24'd0, last_byte});

        // Back-to-back 0x00 then 0xFF with no idle gap
        expect_byte(8'h00, 1'b0);
        expect_byte(8'hFF, 1'b0);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(2 * BIT_CYC);
        check_range("b2b_spacing", last_done - prev_done, 636, 644);

        // Framing error, line held low, then a clean frame
        expect_byte(8'hA3, 1'b1);
        send_frame(8'hA3, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        idle(2 * BIT_CYC);
        expect_byte(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b1);
        idle(2 * BIT_CYC);

        // Reset during data bit 4 of 0x81, then a clean 0x7E frame
        cnt_before = done_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'((8'h81 >> i) & 8'h1));
        rx = 1'b0;
        repeat (BIT_CYC / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midreset_outputs", {21'd0, data, done, err, tick}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_byte = 8'h00;
        idle(2 * BIT_CYC);
        check("midreset_no_done", done_cnt, cnt_before);
        check("midreset_data", {24'd0, data}, 32'h0);
        expect_byte(8'h7E, 1'b0);
        send_frame(8'h7E, 1'b1);
        idle(2 * BIT_CYC);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver with an integrated baud-tick generator; the serial front end of the UART path.
- Takes the asynchronous PC line, recovers 8N1 frames and delivers each byte with a one-cycle done strobe to the RX-side interface that assembles ALU operands.
- Also reports framing errors.
- Replaces the free-standing tick generator plus receiver pair with one self-contained stage.

Parameters:
- NB_DATA, 8: data bits per frame, sent LSB first.
- SB_TICK, 16: oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- BAUD_DIV, 163: clock cycles per oversample tick (50 MHz / (19200 x 16)). Legal range is 2 or more.
- NB_DIV, 8: width of the baud counter. Must satisfy 2^NB_DIV >= BAUD_DIV.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_rx  in  1  serial line from the PC; asynchronous; idles high.
- o_rx_interfaz_data  out  NB_DATA  last received byte; held until the next done.
- o_rx_interfaz_done_data  out  1  one-cycle pulse: o_rx_interfaz_data is valid.
- o_frame_err  out  1  stop bit sampled low for the byte in o_rx_interfaz_data; updated with done.
- o_tick  out  1  oversample tick (debug/observability).

Behaviour:
- Reset (i_rst=0, asynchronous):
  - synchronizer flops = 1, baud counter = 0, state = IDLE, s = 0, n = 0, shift register = 0.
  - All outputs = 0.
  - A reset asserted mid-frame discards the partial byte; no done is issued.
- Synchronizer: i_rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Baud generator:
  - Free-running counter 0..BAUD_DIV-1.
  - o_tick = 1 for the single cycle in which the counter equals BAUD_DIV-1; the counter wraps to 0 on the next cycle.
  - Runs in all states.
- Counters: s = tick counter, 0..31 (5 bits); n = bit counter, 0..NB_DATA-1.
- FSM (all tick-qualified transitions act only in cycles where o_tick = 1):
  - IDLE:
    - rx_s = 0 (tick not required): go to START, s = 0.
  - START:
    - On tick with s = 7 and rx_s = 0 (mid start bit): go to DATA, s = 0, n = 0.
    - On tick with s = 7 and rx_s = 1: glitch. Go to IDLE; no output change.
    - Otherwise on tick: s++.
  - DATA:
    - On tick with s = 15: sample, sh = {rx_s, sh[NB_DATA-1:1]}, s = 0.
      - If n = NB_DATA-1: go to STOP.
      - Else: n++.
    - Otherwise on tick: s++.
  - STOP:
    - On tick with s = SB_TICK-1: register o_rx_interfaz_data = sh and o_frame_err = ~rx_s. Assert done in the next cycle for exactly 1 cycle.
      - If rx_s = 1: go to IDLE.
      - If rx_s = 0: go to BREAK.
    - Otherwise on tick: s++.
  - BREAK:
    - Stay until rx_s = 1, then go to IDLE.
    - Prevents a low line from being decoded as back-to-back 0x00 frames.
- Latency:
  - Line falling edge to START entry: 2–3 cycles (synchronizer).
  - Done fires 1 cycle after the final stop-bit tick, i.e. about 7.5 + 16*NB_DATA + SB_TICK ticks after the start edge.
- Downstream handshake:
  - No backpressure. The consumer must capture on the done cycle.
  - o_rx_interfaz_data is stable from done until the next done.
- Back-to-back frames: a start bit arriving immediately after the stop sample is accepted. IDLE reacts on the first cycle rx_s = 0, with no dead tick.
- Simultaneous events: reset dominates everything. A tick coinciding with the state entry into START counts as that state's first tick.
- The s counter saturates at 31 by construction, since SB_TICK ≤ 32 is required. SB_TICK > 32 is illegal.

Test Plan (BAUD_DIV=4, SB_TICK=16, NB_DATA=8; 1 bit = 64 cycles):
- Clean frame with byte 0x55 (bits 1,0,1,0,... LSB first) → single done pulse, o_rx_interfaz_data = 0x55, o_frame_err = 0, done about 2 cycles after the stop-bit midpoint tick; no second pulse.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two done pulses with data 0x00 then 0xFF, separated by 640 ±4 cycles.
- Start glitch: line low for 12 cycles (3 ticks) then high → FSM returns to IDLE; no done; data holds its prior value.
- Framing error: byte 0xA3 with stop bit = 0, line held low for 3 bit-times, then high, then a clean 0x3C frame → done with 0xA3 and o_frame_err = 1; no done while low; then done with 0x3C and o_frame_err = 0.
- Reset mid-frame: i_rst low for 5 cycles during data bit 4 of 0x81, then a clean 0x7E frame → no done for 0x81; all outputs 0 during reset; next done shows 0x7E.
- Baud tick check: count o_tick over 400 cycles → exactly 100 pulses, each 1 cycle wide, spaced 4 cycles apart.
